// File: rtl/ttl_74x161.sv
// Presettable binary counter (74x161 behaviour) with async active-low clear and ripple carry out.
// Latency: Q updates one CLK edge after load/count; RCO is combinational from Q and ENT.
// Backpressure: none; ENP/ENT gate counting, LOAD_N overrides both.
module ttl_74x161 #(
    parameter int WIDTH = 4
) (
    input  logic             CLK,
    input  logic             CLR_N,
    input  logic             LOAD_N,
    input  logic             ENP,
    input  logic             ENT,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             RCO
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] q_nxt;

    // Load beats count; count needs both enables so a cascade can stall via ENT.
    always_comb begin
        q_nxt = Q;
        if (!LOAD_N) begin
            q_nxt = D;
        end else if (ENP && ENT) begin
            q_nxt = Q + ONE;
        end
    end

    always_ff @(posedge CLK or negedge CLR_N) begin
        if (!CLR_N) begin
            Q <= '0;
        end else begin
            Q <= q_nxt;
        end
    end

    // ENP deliberately excluded so the next stage sees terminal count while this stage is paused.
    assign RCO = ENT & (&Q);

endmodule

// File: tb/tb_ttl_74x161.sv
// Directed bench for ttl_74x161: single 4-bit part plus a two-stage cascade.
module tb_ttl_74x161;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       load_n;
    logic       enp;
    logic       ent;
    logic [3:0] d;
    logic [3:0] q;
    logic       rco;

    logic       cas_load_n;
    logic       cas_enp;
    logic       cas_ent;
    logic [7:0] cas_d;
    logic [3:0] q0;
    logic [3:0] q1;
    logic       rco0;
    logic       rco1;

    int n_chk = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    ttl_74x161 #(.WIDTH(4)) dut (
        .CLK    (clk),
        .CLR_N  (clr_n),
        .LOAD_N (load_n),
        .ENP    (enp),
        .ENT    (ent),
        .D      (d),
        .Q      (q),
        .RCO    (rco)
    );

    ttl_74x161 #(.WIDTH(4)) cas_lo (
        .CLK    (clk),
        .CLR_N  (clr_n),
        .LOAD_N (cas_load_n),
        .ENP    (cas_enp),
        .ENT    (cas_ent),
        .D      (cas_d[3:0]),
        .Q      (q0),
        .RCO    (rco0)
    );

    ttl_74x161 #(.WIDTH(4)) cas_hi (
        .CLK    (clk),
        .CLR_N  (clr_n),
        .LOAD_N (cas_load_n),
        .ENP    (cas_enp),
        .ENT    (rco0),
        .D      (cas_d[7:4]),
        .Q      (q1),
        .RCO    (rco1)
    );

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [3:0] val);
        load_n = 1'b0;
        d      = val;
        tick();
        load_n = 1'b1;
    endtask

    initial begin
        clr_n      = 1'b0;
        load_n     = 1'b0;
        enp        = 1'b1;
        ent        = 1'b1;
        d          = 4'hA;
        cas_load_n = 1'b1;
        cas_enp    = 1'b0;
        cas_ent    = 1'b0;
        cas_d      = 8'h00;

        // Clear held across edges with load and count requested.
        #1;
        chk("rst_q", 16'(q), 16'h0);
        chk("rst_rco", 16'(rco), 16'h0);
        for (int i = 0; i < 2; i++) begin
            tick();
            chk("rst_hold_q", 16'(q), 16'h0);
            chk("rst_hold_rco", 16'(rco), 16'h0);
        end
        clr_n = 1'b1;
        tick();
        chk("rst_release_load", 16'(q), 16'hA);

        // Free count from 0 through wrap.
        load(4'h0);
        chk("load_zero", 16'(q), 16'h0);
        enp = 1'b1;
        ent = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            tick();
            chk("count_q", 16'(q), 16'(i));
            chk("count_rco", 16'(rco), (i == 15) ? 16'h1 : 16'h0);
        end
        tick();
        chk("wrap_q", 16'(q), 16'h0);
        chk("wrap_rco", 16'(rco), 16'h0);

        // Enable gating at terminal count.
        load(4'hF);
        enp = 1'b0;
        ent = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("enp_off_q", 16'(q), 16'hF);
            chk("enp_off_rco", 16'(rco), 16'h1);
        end
        ent = 1'b0;
        #1;
        chk("ent_off_rco_comb", 16'(rco), 16'h0);
        enp = 1'b1;
        tick();
        chk("ent_off_q", 16'(q), 16'hF);
        chk("ent_off_rco", 16'(rco), 16'h0);

        // Load beats count.
        ent = 1'b1;
        load(4'h3);
        chk("load_3", 16'(q), 16'h3);
        load_n = 1'b0;
        d      = 4'hC;
        tick();
        chk("load_prio", 16'(q), 16'hC);

        // Loading all ones raises RCO only after the edge.
        d = 4'hF;
        #1;
        chk("load_f_pre_rco", 16'(rco), 16'h0);
        tick();
        load_n = 1'b1;
        chk("load_f_rco", 16'(rco), 16'h1);

        // Async clear between edges mid-count.
        load(4'h6);
        tick();
        chk("pre_clr_q", 16'(q), 16'h7);
        #3;
        clr_n = 1'b0;
        #2;
        chk("async_clr_q", 16'(q), 16'h0);
        clr_n = 1'b1;
        tick();
        chk("post_clr_q", 16'(q), 16'h1);

        // Two-stage cascade: 0x0E -> 0x10, then a full 256-cycle lap.
        cas_load_n = 1'b0;
        cas_d      = 8'h0E;
        tick();
        cas_load_n = 1'b1;
        chk("cas_load", 16'({q1, q0}), 16'h0E);
        cas_enp = 1'b1;
        cas_ent = 1'b1;
        tick();
        chk("cas_0f", 16'({q1, q0}), 16'h0F);
        chk("cas_0f_rco1", 16'(rco1), 16'h0);
        tick();
        chk("cas_10", 16'({q1, q0}), 16'h10);
        for (int i = 1; i <= 256; i++) begin
            logic [7:0] exp_v;
            exp_v = 8'(8'h10 + i);
            tick();
            chk("cas_lap", 16'({q1, q0}), 16'(exp_v));
            chk("cas_rco1", 16'(rco1), (exp_v == 8'hFF) ? 16'h1 : 16'h0);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
